mod_sub_arbiter: RTL and testbench
==================================

Name: mod_sub_arbiter

Overview:
Round-robin arbiter and sequencer that shares one combinational mod_sub datapath (R = (A − B) mod p, secp256k1 prime) between NUM_REQ requesters, e.g. the point-add and point-double engines.
- Per-requester request/response valid-ready handshakes.
- Latches the granted operands and registers the result.
- Returns the result and tag to the granted requester.
- Exactly one operation in flight at a time.

Parameters:
NUM_REQ, 4, number of requesters (2..8); index width IW = $clog2(NUM_REQ)
TAG_W, 4, width of the per-request tag echoed with the result

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester request ready (one-hot or zero)
req_a  input  NUM_REQ*256  packed minuends; requester i uses bits [256*i +: 256]
req_b  input  NUM_REQ*256  packed subtrahends, same packing
req_tag  input  NUM_REQ*TAG_W  packed tags
rsp_valid  output  NUM_REQ  one-hot response valid to the owning requester
rsp_ready  input  NUM_REQ  per-requester response ready
rsp_r  output  256  result (A − B) mod p, shared bus
rsp_tag  output  TAG_W  tag of the completed request
rsp_err  output  1  operand range flag (see Optional Feature)
busy  output  1  high in EXEC or RESP
grant_idx  output  IW  index of current/last granted requester

Behaviour:
- Reset: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_r=0, rsp_tag=0, rsp_err=0, busy=0, grant_idx=0, operand registers=0.
- FSM IDLE → EXEC → RESP → IDLE.
- IDLE:
  - req_ready is combinational and one-hot at the round-robin winner: the first asserted req_valid at or after rr_ptr, wrapping modulo NUM_REQ.
  - req_ready=0 if no req_valid is asserted.
  - On handshake (req_valid[g] & req_ready[g]): latch req_a/req_b/req_tag slices of g into op_a/op_b/op_tag; grant_idx←g; rr_ptr←(g+1) mod NUM_REQ; go to EXEC.
- EXEC (1 cycle):
  - Internal mod_sub instance driven by op_a/op_b.
  - rsp_r←R, rsp_tag←op_tag, rsp_err per feature; go to RESP.
  - req_ready=0.
- RESP:
  - rsp_valid[grant_idx]=1, all other rsp_valid bits 0.
  - rsp_r, rsp_tag and rsp_err stay stable until handshake.
  - Only rsp_ready[grant_idx] is honoured; other rsp_ready bits are ignored.
  - On handshake: rsp_valid→0; go to IDLE.
  - req_ready=0.
- Latency: rsp_valid rises 2 cycles after the request handshake. Minimum spacing between accepts is 3 cycles (accept, EXEC, RESP with rsp_ready=1); the next accept can occur in the cycle after the response handshake.
- Arithmetic:
  - Unreduced operands (≥ p) are passed through unchanged.
  - A=B → 0.
  - A<B → p − (B − A).
  - No overflow beyond 256 bits.
- Requester drops req_valid before ready: no effect; arbitration is re-evaluated each IDLE cycle.
- req_valid asserted for a non-granted requester: it waits, with no starvation. Round-robin bounds its wait to at most NUM_REQ−1 other grants.
- Reset asserted mid-operation (EXEC or RESP): the operation is discarded, nothing is delivered, and all outputs return to reset values asynchronously.
- Operand and tag slices of non-granted requesters are don't-care.

Optional Feature:
Macro MODSUB_RANGE_CHECK_EN.
- Defined: in EXEC, rsp_err←(op_a ≥ p) | (op_b ≥ p). rsp_err is valid with rsp_valid, and the result is still delivered.
- Undefined: no comparators are built and rsp_err is constant 0.

Test Plan:
- Basic subtraction: requester 0 sends A=5, B=3, tag=1 → rsp_valid=0001 two cycles after accept, rsp_r=2, rsp_tag=1.
- Negative wrap: requester 2 sends A=3, B=5 → rsp_r=FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2D.
- Equal operands: A=B=0x1234 → rsp_r=0.
- Round-robin: all 4 requesters hold req_valid with rsp_ready tied to 1 → grant order 0,1,2,3,0 with accepts every 3 cycles; continuing only req 1 and 3 from rr_ptr=1 → 1,3,1,3.
- Backpressure and reset:
  - rsp_ready low for 5 cycles in RESP → rsp_valid, rsp_r and rsp_tag held, req_ready=0 throughout.
  - rsp_ready asserted on a non-owner bit → no completion.
  - rst pulsed during EXEC → all outputs 0 on the same cycle, no rsp_valid afterwards.
- MODSUB_RANGE_CHECK_EN defined: A=p, B=1 → rsp_err=1, rsp_r=p−1. A=7, B=2 → rsp_err=0. Macro undefined, A=p → rsp_err=0.

Source files
------------

// File: rtl/mod_sub_arbiter.sv
// rtl/mod_sub_arbiter.sv - round-robin arbiter sharing one (A-B) mod p datapath; optional MODSUB_RANGE_CHECK_EN

module mod_sub_core (
    input  logic [255:0] a,
    input  logic [255:0] b,
    output logic [255:0] r
);
    localparam logic [255:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    logic [256:0] diff;

    // A borrow out of A-B means A<B; adding p folds the wrapped difference back into range
    always_comb begin
        diff = {1'b0, a} - {1'b0, b};
        r    = diff[256] ? (diff[255:0] + P) : diff[255:0];
    end
endmodule

module mod_sub_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 4,
    localparam int IW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*256-1:0]   req_a,
    input  logic [NUM_REQ*256-1:0]   req_b,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [255:0]             rsp_r,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [IW-1:0]            grant_idx
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    localparam logic [IW:0]   NREQ_W   = (IW+1)'(NUM_REQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    state_t               state_q, state_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]        grant_q, grant_d;
    logic [255:0]         op_a_q, op_a_d;
    logic [255:0]         op_b_q, op_b_d;
    logic [TAG_W-1:0]     op_tag_q, op_tag_d;
    logic [255:0]         rsp_r_q, rsp_r_d;
    logic [TAG_W-1:0]     rsp_tag_q, rsp_tag_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic                 busy_q, busy_d;

    logic                 win_found;
    logic [IW-1:0]        win_idx;
    logic [IW:0]          cand;
    logic [255:0]         core_r;
    logic                 range_err;

    mod_sub_core u_core (
        .a (op_a_q),
        .b (op_b_q),
        .r (core_r)
    );

`ifdef MODSUB_RANGE_CHECK_EN
    localparam logic [255:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    assign range_err = (op_a_q >= P) | (op_b_q >= P);
`else
    assign range_err = 1'b0;
`endif

    // Round-robin scan: first asserted request at or after rr_ptr, wrapping
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + k[IW:0];
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!win_found && req_valid[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end

    // Ready is offered only in IDLE, one-hot at the winner; forced low while reset is held
    always_comb begin
        req_ready = '0;
        if (!rst && state_q == S_IDLE && win_found) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    // Next-state and datapath register updates for the IDLE -> EXEC -> RESP sequence
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_tag_d    = op_tag_q;
        rsp_r_d     = rsp_r_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_err_d   = rsp_err_q;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d  = S_EXEC;
                    grant_d  = win_idx;
                    rr_ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
                    op_a_d   = req_a[{win_idx, 8'd0} +: 256];
                    op_b_d   = req_b[{win_idx, 8'd0} +: 256];
                    op_tag_d = req_tag[int'(win_idx) * TAG_W +: TAG_W];
                    busy_d   = 1'b1;
                end
            end
            S_EXEC: begin
                state_d              = S_RESP;
                rsp_r_d              = core_r;
                rsp_tag_d            = op_tag_q;
                rsp_err_d            = range_err;
                rsp_valid_d          = '0;
                rsp_valid_d[grant_q] = 1'b1;
            end
            S_RESP: begin
                // Only the owner's ready completes the response
                if (rsp_ready[grant_q]) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = '0;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset discards any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_tag_q    <= '0;
            rsp_r_q     <= '0;
            rsp_tag_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_tag_q    <= op_tag_d;
            rsp_r_q     <= rsp_r_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign grant_idx = grant_q;
endmodule

// File: tb/tb_mod_sub_arbiter.sv
// tb/tb_mod_sub_arbiter.sv - randomized and directed bench for mod_sub_arbiter against a transaction model
module tb_mod_sub_arbiter;
    localparam int NUM_REQ = 4;
    localparam int TAG_W   = 4;
    localparam int IW      = 2;
    localparam logic [255:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
`ifdef MODSUB_RANGE_CHECK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*256-1:0]   req_a;
    logic [NUM_REQ*256-1:0]   req_b;
    logic [NUM_REQ*TAG_W-1:0] req_tag;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [NUM_REQ-1:0]       rsp_ready;
    logic [255:0]             rsp_r;
    logic [TAG_W-1:0]         rsp_tag;
    logic                     rsp_err;
    logic                     busy;
    logic [IW-1:0]            grant_idx;

    int n_checks;
    int n_errors;

    // transaction-level model state
    bit               m_busy;
    int               m_age;
    int               m_owner;
    int               m_grant;
    int               m_rr;
    logic [255:0]     m_r;
    logic [TAG_W-1:0] m_tag;
    logic             m_err;

    mod_sub_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_r     (rsp_r),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [255:0] ref_sub(input logic [255:0] a, input logic [255:0] b);
        if (a >= b) return a - b;
        return P - (b - a);
    endfunction

    function automatic int winner(input logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(m_rr + k) % NUM_REQ]) return (m_rr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        case ($urandom_range(0, 7))
            0: v = P;
            1: v = P - 256'd1;
            2: v = '0;
            3: v = '1;
            4: v = 256'($urandom_range(0, 15));
            default: ;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_owner = 0; m_grant = 0; m_rr = 0;
        m_r = '0; m_tag = '0; m_err = 1'b0;
    endtask

    // advance the model across one rising edge using the inputs present at that edge
    task automatic model_update();
        int w;
        logic [255:0] a, b;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_busy) begin
            if (m_age >= 2 && rsp_ready[m_owner]) m_busy = 0;
            else if (m_age < 2) m_age++;
        end else begin
            w = winner(req_valid);
            if (w >= 0) begin
                a = req_a[256*w +: 256];
                b = req_b[256*w +: 256];
                m_busy  = 1;
                m_age   = 1;
                m_owner = w;
                m_grant = w;
                m_rr    = (w + 1) % NUM_REQ;
                m_r     = ref_sub(a, b);
                m_tag   = req_tag[TAG_W*w +: TAG_W];
                m_err   = ERR_ON & ((a >= P) | (b >= P));
            end
        end
    endtask

    task automatic compare();
        logic [NUM_REQ-1:0] e_rdy, e_vld;
        int w;
        if (rst) begin
            chk("rst_req_ready", 256'(req_ready), 256'd0);
            chk("rst_rsp_valid", 256'(rsp_valid), 256'd0);
            chk("rst_rsp_r", rsp_r, 256'd0);
            chk("rst_rsp_tag", 256'(rsp_tag), 256'd0);
            chk("rst_rsp_err", 256'(rsp_err), 256'd0);
            chk("rst_busy", 256'(busy), 256'd0);
            chk("rst_grant_idx", 256'(grant_idx), 256'd0);
            return;
        end
        e_rdy = '0;
        e_vld = '0;
        if (!m_busy) begin
            w = winner(req_valid);
            if (w >= 0) e_rdy[w] = 1'b1;
        end
        if (m_busy && m_age >= 2) e_vld[m_owner] = 1'b1;
        chk("req_ready", 256'(req_ready), 256'(e_rdy));
        chk("rsp_valid", 256'(rsp_valid), 256'(e_vld));
        chk("busy", 256'(busy), 256'(m_busy));
        chk("grant_idx", 256'(grant_idx), 256'(m_grant));
        if (e_vld != '0) begin
            chk("rsp_r", rsp_r, m_r);
            chk("rsp_tag", 256'(rsp_tag), 256'(m_tag));
            chk("rsp_err", 256'(rsp_err), 256'(m_err));
        end
    endtask

    // one clock: compare on the falling edge, update the model on the rising edge, return 1 after it
    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_op(input int i, input logic [255:0] a, input logic [255:0] b,
                         input logic [TAG_W-1:0] tag, input logic [255:0] exp_r,
                         input logic exp_err, input int hold);
        logic [NUM_REQ-1:0] me;
        me = '0;
        me[i] = 1'b1;
        req_valid = me;
        req_a[256*i +: 256] = a;
        req_b[256*i +: 256] = b;
        req_tag[TAG_W*i +: TAG_W] = tag;
        rsp_ready = '0;
        #1 chk("op_req_ready", 256'(req_ready), 256'(me));
        step();
        req_valid = '0;
        #1 chk("op_exec_rsp_valid", 256'(rsp_valid), 256'd0);
        chk("op_exec_busy", 256'(busy), 256'd1);
        step();
        chk("op_rsp_valid", 256'(rsp_valid), 256'(me));
        chk("op_rsp_r", rsp_r, exp_r);
        chk("op_rsp_tag", 256'(rsp_tag), 256'(tag));
        chk("op_rsp_err", 256'(rsp_err), 256'(exp_err));
        for (int h = 0; h < hold; h++) begin
            req_valid = ~me;
            rsp_ready = ~me;
            #1 chk("hold_req_ready", 256'(req_ready), 256'd0);
            step();
            chk("hold_rsp_valid", 256'(rsp_valid), 256'(me));
            chk("hold_rsp_r", rsp_r, exp_r);
            chk("hold_rsp_tag", 256'(rsp_tag), 256'(tag));
        end
        req_valid = '0;
        rsp_ready = me;
        step();
        chk("op_done_rsp_valid", 256'(rsp_valid), 256'd0);
        chk("op_done_busy", 256'(busy), 256'd0);
        rsp_ready = '0;
    endtask

    function automatic int idx_of(input logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++) if (v[k]) return k;
        return -1;
    endfunction

    initial begin
        int acc_idx[$];
        int acc_cyc[$];
        int exp_order[9];
        int cyc;

        n_checks = 0;
        n_errors = 0;
        model_reset();
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        step();
        step();
        chk("reset_req_ready", 256'(req_ready), 256'd0);
        chk("reset_busy", 256'(busy), 256'd0);
        chk("reset_rsp_r", rsp_r, 256'd0);
        rst = 1'b0;
        req_valid = '0;
        step();

        do_op(0, 256'd5, 256'd3, 4'd1, 256'd2, 1'b0, 0);
        do_op(2, 256'd3, 256'd5, 4'd9,
              256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2D, 1'b0, 5);
        do_op(1, 256'h1234, 256'h1234, 4'd7, 256'd0, 1'b0, 0);
        do_op(0, 256'd7, 256'd2, 4'd3, 256'd5, 1'b0, 0);
        do_op(3, P, 256'd1, 4'd5, P - 256'd1, ERR_ON, 0);

        // round robin with everyone requesting and responses always accepted
        exp_order = '{0, 1, 2, 3, 0, 1, 3, 1, 3};
        req_valid = '1;
        rsp_ready = '1;
        cyc = 0;
        while (acc_idx.size() < 9 && cyc < 80) begin
            if (acc_idx.size() == 5) req_valid = 4'b1010;
            #1;
            if ((req_ready & req_valid) != '0) begin
                acc_idx.push_back(idx_of(req_ready));
                acc_cyc.push_back(cyc);
            end
            step();
            cyc++;
        end
        chk("rr_accept_count", 256'(acc_idx.size()), 256'd9);
        for (int k = 0; k < 9; k++) begin
            if (k < acc_idx.size()) chk("rr_order", 256'(acc_idx[k]), 256'(exp_order[k]));
            if (k > 0 && k < acc_idx.size()) chk("rr_spacing", 256'(acc_cyc[k] - acc_cyc[k-1]), 256'd3);
        end
        req_valid = '0;
        cyc = 0;
        while (busy && cyc < 10) begin
            step();
            cyc++;
        end
        chk("rr_drained", 256'(busy), 256'd0);

        // reset asserted while the operation is in EXEC
        req_valid = 4'b0010;
        req_a[256 +: 256] = 256'd100;
        req_b[256 +: 256] = 256'd1;
        step();
        req_valid = '0;
        rsp_ready = '1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_rsp_valid", 256'(rsp_valid), 256'd0);
        chk("midrst_busy", 256'(busy), 256'd0);
        chk("midrst_grant_idx", 256'(grant_idx), 256'd0);
        chk("midrst_rsp_r", rsp_r, 256'd0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("midrst_no_delivery", 256'(rsp_valid), 256'd0);

        // randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_a[256*i +: 256] = rand256();
                req_b[256*i +: 256] = rand256();
                req_tag[TAG_W*i +: TAG_W] = TAG_W'($urandom);
            end
            req_valid = NUM_REQ'($urandom) & NUM_REQ'($urandom | $urandom);
            rsp_ready = NUM_REQ'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
